// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, divider quotient width,
// divider state encoding and a parameter legality helper.
package fpu_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int QBITS      = 26;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } fdiv_state_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  // Only divisors of the quotient width give a whole number of DIV cycles.
  function automatic bit bpc_legal(int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 13) || (bpc == 26);
  endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the iterative divider.
interface fdiv_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y
  );

endinterface

// File: rtl/fdiv_special.sv
// Operand classification for the simplified binary32 model: exponent field 0
// is zero, exponent field 255 is infinity. Shared with fmul.
module fdiv_special
  import fpu_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  force_zero,
  output logic  force_inf,
  output logic  sign
);

  // Priority-ordered special-case decode; zero/inf are mutually exclusive.
  always_comb begin
    force_zero = 1'b0;
    force_inf  = 1'b0;
    sign       = a.sign ^ b.sign;
    if (a.exp == '0) begin
      force_zero = 1'b1;
    end else if (b.exp == '0) begin
      force_inf = 1'b1;
    end else if (a.exp == '1) begin
      force_inf = 1'b1;
    end else if (b.exp == '1) begin
      force_zero = 1'b1;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider y = x1 / x2 with restoring mantissa division.
// Optional macro FDIV_ROUND_NEAREST_EN: round to nearest, ties to even;
// without it the result is truncated toward zero, matching fmul.
// NORM takes two cycles (normalise, then round/range/special), so the
// latency from acceptance to out_valid is QBITS/BITS_PER_CYCLE + 2.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic     clk,
  input  logic     rstn,
  fdiv_seq_if.slave bus
);

  localparam int                 N          = QBITS / BITS_PER_CYCLE;
  localparam logic [4:0]         LAST_ITER  = 5'(N - 1);
  localparam logic signed [9:0]  EXP_BIAS_S = 10'(FP_BIAS);
  localparam logic signed [9:0]  EXP_MAX_S  = 10'(FP_EXP_MAX);

  generate
    if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
      $fatal(1, "fdiv_seq: BITS_PER_CYCLE must be 1, 2, 13 or 26");
    end
  endgenerate

  fdiv_state_t        state;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        y_r;
  logic [4:0]         iter_cnt;
  logic               sign_r;
  logic               force_zero_r;
  logic               force_inf_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        m2_r;
  logic [24:0]        rem_r;
  logic [QBITS-1:0]   q_r;
  logic [FP_FRAC_W-1:0] frac_r;
`ifdef FDIV_ROUND_NEAREST_EN
  logic               guard_r;
  logic               sticky_r;
`endif

  fp32_t a;
  fp32_t b;
  logic  sp_zero;
  logic  sp_inf;
  logic  sp_sign;

  assign a = bus.x1;
  assign b = bus.x2;

  fdiv_special u_special (
    .a          (a),
    .b          (b),
    .force_zero (sp_zero),
    .force_inf  (sp_inf),
    .sign       (sp_sign)
  );

  logic [24:0]        rem_nxt;
  logic [QBITS-1:0]   q_nxt;

  // Retire BITS_PER_CYCLE restoring-division steps; remainder stays below 2*m2.
  always_comb begin
    rem_nxt = rem_r;
    q_nxt   = q_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_nxt >= {1'b0, m2_r}) begin
        q_nxt   = {q_nxt[QBITS-2:0], 1'b1};
        rem_nxt = (rem_nxt - {1'b0, m2_r}) << 1;
      end else begin
        q_nxt   = {q_nxt[QBITS-2:0], 1'b0};
        rem_nxt = rem_nxt << 1;
      end
    end
  end

  logic                 round_up;
  logic signed [9:0]    rnd_exp;
  logic [FP_FRAC_W-1:0] rnd_frac;
  logic [31:0]          y_nxt;

  // Rounding, exponent range limits and special-case override of the result.
  always_comb begin
    round_up = 1'b0;
`ifdef FDIV_ROUND_NEAREST_EN
    round_up = guard_r & (sticky_r | frac_r[0]);
`endif
    {rnd_exp, rnd_frac} = {exp_r, frac_r} + 33'(round_up);
    if (force_zero_r) begin
      y_nxt = {sign_r, 31'b0};
    end else if (force_inf_r) begin
      y_nxt = {sign_r, 8'hFF, 23'b0};
    end else if (rnd_exp <= 10'sd0) begin
      y_nxt = {sign_r, 31'b0};
    end else if (rnd_exp >= EXP_MAX_S) begin
      y_nxt = {sign_r, 8'hFF, 23'b0};
    end else begin
      y_nxt = {sign_r, rnd_exp[7:0], rnd_frac};
    end
  end

  // Control FSM and datapath registers; handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      iter_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r       <= sp_sign;
            force_zero_r <= sp_zero;
            force_inf_r  <= sp_inf;
            exp_r        <= $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + EXP_BIAS_S;
            rem_r        <= {2'b01, a.frac};
            m2_r         <= {1'b1, b.frac};
            q_r          <= '0;
            iter_cnt     <= '0;
            in_ready_r   <= 1'b0;
            state        <= DIV;
          end
        end
        DIV: begin
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
          if (iter_cnt == LAST_ITER) begin
            iter_cnt <= '0;
            state    <= NORM;
          end else begin
            iter_cnt <= iter_cnt + 5'd1;
          end
        end
        NORM: begin
          if (iter_cnt == 5'd0) begin
            if (q_r[QBITS-1]) begin
              frac_r <= q_r[24:2];
`ifdef FDIV_ROUND_NEAREST_EN
              guard_r <= q_r[1];
`endif
            end else begin
              frac_r <= q_r[23:1];
              exp_r  <= exp_r - 10'sd1;
`ifdef FDIV_ROUND_NEAREST_EN
              guard_r <= q_r[0];
`endif
            end
`ifdef FDIV_ROUND_NEAREST_EN
            sticky_r <= |rem_r;
`endif
            iter_cnt <= 5'd1;
          end else begin
            y_r         <= y_nxt;
            out_valid_r <= 1'b1;
            iter_cnt    <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: expected quotients are queued when operands
// are accepted and compared when the result handshake is observed.
module tb_fdiv_seq;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fdiv_seq_if bus ();
  fdiv_seq_if bus13 ();

  fdiv_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  fdiv_seq #(.BITS_PER_CYCLE(13)) dut13 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus13)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] sb_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.x1       = a;
    bus.x2       = b;
    sb_q.push_back(expv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x1       = $urandom;
    bus.x2       = $urandom;
  endtask

  task automatic waitResult(input int lat);
    int          k;
    logic        ready_bad;
    logic [31:0] expv;
    k         = 0;
    ready_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (bus.in_ready !== 1'b0) ready_bad = 1'b1;
    end
    checkOutput("latency", 32'(k), 32'(lat));
    checkOutput("in_ready_busy", 32'(ready_bad), 32'd0);
    expv = 32'hDEADBEEF;
    if (sb_q.size() > 0) expv = sb_q.pop_front();
    checkOutput("y", bus.y, expv);
  endtask

  task automatic completeHandshake();
    @(posedge clk); #1;
    checkOutput("out_valid_drop", 32'(bus.out_valid), 32'd0);
    checkOutput("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_third;
    logic [31:0] held_y;
    logic        y_bad;
    logic        rdy_bad;
    logic        vld_bad;
    logic        spurious;
    int          k;

`ifdef FDIV_ROUND_NEAREST_EN
    exp_third = 32'h3EAAAAAB;
`else
    exp_third = 32'h3EAAAAAA;
`endif

    rstn            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.x1          = '0;
    bus.x2          = '0;
    bus.out_ready   = 1'b1;
    bus13.in_valid  = 1'b0;
    bus13.x1        = '0;
    bus13.x2        = '0;
    bus13.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_y", bus.y, 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_in_ready_bpc13", 32'(bus13.in_ready), 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] exact and inexact quotients");
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000);
    waitResult(28);
    completeHandshake();
    applyStimulus(32'h3F800000, 32'h40400000, exp_third);
    waitResult(28);
    completeHandshake();

    $display("[TB] special cases");
    applyStimulus(32'hBF800000, 32'h00000000, 32'hFF800000);
    waitResult(28);
    completeHandshake();
    applyStimulus(32'h00000000, 32'h00000000, 32'h00000000);
    waitResult(28);
    completeHandshake();
    applyStimulus(32'h3F800000, 32'h7F800000, 32'h00000000);
    waitResult(28);
    completeHandshake();

    $display("[TB] range limits");
    applyStimulus(32'h00800000, 32'h40000000, 32'h00000000);
    waitResult(28);
    completeHandshake();
    applyStimulus(32'h7F000000, 32'h3F000000, 32'h7F800000);
    waitResult(28);
    completeHandshake();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(32'h40000000, 32'h3F800000, 32'h40000000);
    waitResult(28);
    held_y  = bus.y;
    y_bad   = 1'b0;
    rdy_bad = 1'b0;
    vld_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.x1       = $urandom;
      bus.x2       = $urandom;
      @(posedge clk); #1;
      if (bus.y !== held_y) y_bad = 1'b1;
      if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
      if (bus.out_valid !== 1'b1) vld_bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_y_stable", 32'(y_bad), 32'd0);
    checkOutput("bp_in_ready_low", 32'(rdy_bad), 32'd0);
    checkOutput("bp_out_valid_held", 32'(vld_bad), 32'd0);
    bus.out_ready = 1'b1;
    completeHandshake();
    spurious = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious = 1'b1;
    end
    checkOutput("bp_pulses_ignored", 32'(spurious), 32'd0);

    $display("[TB] reset during DIV");
    bus.in_valid = 1'b1;
    bus.x1       = 32'h3F800000;
    bus.x2       = 32'h40400000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_y", bus.y, 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000);
    waitResult(28);
    completeHandshake();

    $display("[TB] BITS_PER_CYCLE = 13");
    checkOutput("bpc13_in_ready", 32'(bus13.in_ready), 32'd1);
    bus13.in_valid = 1'b1;
    bus13.x1       = 32'h40C00000;
    bus13.x2       = 32'h40000000;
    sb_q.push_back(32'h40400000);
    @(posedge clk); #1;
    bus13.in_valid = 1'b0;
    bus13.x1       = $urandom;
    bus13.x2       = $urandom;
    k = 0;
    while (bus13.out_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("bpc13_latency", 32'(k), 32'd4);
    held_y = 32'hDEADBEEF;
    if (sb_q.size() > 0) held_y = sb_q.pop_front();
    checkOutput("bpc13_y", bus13.y, held_y);
    @(posedge clk); #1;
    checkOutput("bpc13_out_valid_drop", 32'(bus13.out_valid), 32'd0);
    checkOutput("bpc13_in_ready_back", 32'(bus13.in_ready), 32'd1);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
